// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i core: sequencer states, opcode and
// jump/writeback codes, and the canonical NOP.
package rv32i_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] JMP_NONE   = 2'd0;
  localparam logic [1:0] JMP_JAL    = 2'd1;
  localparam logic [1:0] JMP_JALR   = 2'd2;
  localparam logic [1:0] JMP_BRANCH = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Branches, stores and x0 destinations never write the register file.
  function automatic logic writes_rd(input logic [6:0] opc, input logic [4:0] rd);
    return (rd != 5'd0) &&
           (opc inside {OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR});
  endfunction

endpackage

// File: rtl/rv32i_sequencer_if.sv
// Memory handshakes plus decoder/ALU/register-file hookup of the sequencer.
interface rv32i_sequencer_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_ir;
  logic [31:0] o_pc;
  logic        i_illegal;
  logic [1:0]  i_jump;
  logic [31:0] i_jump_addr;
  logic [31:0] i_branch_target;
  logic [31:0] i_alu_result;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic        i_dmem_ack;
  logic        o_rf_we;
  logic [1:0]  o_wb_sel;
  logic        o_trap;
  logic [2:0]  o_state;

  modport master (
    output o_imem_req, o_imem_addr, o_ir, o_pc, o_dmem_req, o_dmem_we, o_dmem_addr,
           o_rf_we, o_wb_sel, o_trap, o_state,
    input  i_imem_ack, i_imem_rdata, i_illegal, i_jump, i_jump_addr, i_branch_target,
           i_alu_result, i_dmem_ack
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_ir, o_pc, o_dmem_req, o_dmem_we, o_dmem_addr,
           o_rf_we, o_wb_sel, o_trap, o_state,
    output i_imem_ack, i_imem_rdata, i_illegal, i_jump, i_jump_addr, i_branch_target,
           i_alu_result, i_dmem_ack
  );
endinterface

// File: rtl/rv32i_sequencer_next_pc.sv
// Combinational next-PC selector; flags redirect targets that are not word aligned.
module rv32i_next_pc
  import rv32i_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_jump,
  input  logic [31:0] i_jump_addr,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_next_pc,
  output logic        o_misalign
);
  logic [31:0] tgt;
  logic        redirect;

  always_comb begin
    tgt      = i_pc + 32'd4;
    redirect = 1'b0;
    case (i_jump)
      JMP_JAL: begin
        tgt      = i_jump_addr;
        redirect = 1'b1;
      end
      JMP_JALR: begin
        tgt      = {i_alu_result[31:1], 1'b0};
        redirect = 1'b1;
      end
      JMP_BRANCH: if (i_alu_result[0]) begin
        tgt      = i_branch_target;
        redirect = 1'b1;
      end
      default: ;
    endcase
    o_next_pc  = tgt;
    o_misalign = redirect & tgt[1];
  end
endmodule

// File: rtl/rv32i_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for rv32i.
// Define RV32I_SEQ_TRAP_EN to trap on illegal instructions and misaligned targets.
module rv32i_sequencer
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef RV32I_SEQ_TRAP_EN
  , parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  rv32i_sequencer_if.master  bus
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, npc_q, npc_d, daddr_q, daddr_d;
  logic        ireq_q, ireq_d, dreq_q, dreq_d, dwe_q, dwe_d, rfwe_q, rfwe_d;
  logic [1:0]  wbsel_q, wbsel_d;
  logic [31:0] npc_calc;
  logic        misalign;
  logic [6:0]  opc;
  logic        is_mem;

  assign opc    = ir_q[6:0];
  assign is_mem = (opc == OPC_LOAD) || (opc == OPC_STORE);

  rv32i_next_pc u_next_pc (
    .i_pc            (pc_q),
    .i_jump          (bus.i_jump),
    .i_jump_addr     (bus.i_jump_addr),
    .i_branch_target (bus.i_branch_target),
    .i_alu_result    (bus.i_alu_result),
    .o_next_pc       (npc_calc),
    .o_misalign      (misalign)
  );

`ifdef RV32I_SEQ_TRAP_EN
  logic trap_q, trap_d;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    daddr_d = daddr_q;
    ireq_d  = ireq_q;
    dreq_d  = dreq_q;
    dwe_d   = dwe_q;
    wbsel_d = wbsel_q;
    rfwe_d  = 1'b0;
`ifdef RV32I_SEQ_TRAP_EN
    trap_d  = 1'b0;
`endif
    case (state_q)
      // Request rises one cycle after entering FETCH from reset; acks with
      // the request low are ignored.
      ST_FETCH: begin
        if (!ireq_q) begin
          ireq_d = 1'b1;
        end else if (bus.i_imem_ack) begin
          ireq_d  = 1'b0;
          ir_d    = bus.i_imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (bus.i_illegal) begin
`ifdef RV32I_SEQ_TRAP_EN
          state_d = ST_TRAP;
          trap_d  = 1'b1;
`else
          state_d = ST_WB;
          npc_d   = pc_q + 32'd4;
          wbsel_d = WB_ALU;
`endif
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        daddr_d = bus.i_alu_result;
        npc_d   = npc_calc;
        if (opc == OPC_LOAD)                           wbsel_d = WB_LOAD;
        else if (opc == OPC_JAL || opc == OPC_JALR)    wbsel_d = WB_PC4;
        else                                           wbsel_d = WB_ALU;
        if (is_mem) begin
          state_d = ST_MEM;
          dreq_d  = 1'b1;
          dwe_d   = (opc == OPC_STORE);
        end else begin
          state_d = ST_WB;
          rfwe_d  = writes_rd(opc, ir_q[11:7]);
        end
`ifdef RV32I_SEQ_TRAP_EN
        if (misalign) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          rfwe_d  = 1'b0;
          dreq_d  = 1'b0;
        end
`endif
      end
      ST_MEM: begin
        if (bus.i_dmem_ack) begin
          dreq_d  = 1'b0;
          state_d = ST_WB;
          rfwe_d  = writes_rd(opc, ir_q[11:7]);
        end
      end
      // Request is raised here so the next FETCH cycle already presents it.
      ST_WB: begin
        pc_d    = npc_q;
        ireq_d  = 1'b1;
        state_d = ST_FETCH;
      end
`ifdef RV32I_SEQ_TRAP_EN
      ST_TRAP: begin
        pc_d    = TRAP_VECTOR;
        ireq_d  = 1'b1;
        state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      npc_q   <= RESET_PC;
      daddr_q <= '0;
      ireq_q  <= 1'b0;
      dreq_q  <= 1'b0;
      dwe_q   <= 1'b0;
      rfwe_q  <= 1'b0;
      wbsel_q <= WB_ALU;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      daddr_q <= daddr_d;
      ireq_q  <= ireq_d;
      dreq_q  <= dreq_d;
      dwe_q   <= dwe_d;
      rfwe_q  <= rfwe_d;
      wbsel_q <= wbsel_d;
    end
  end

`ifdef RV32I_SEQ_TRAP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) trap_q <= 1'b0;
    else          trap_q <= trap_d;
  end
  assign bus.o_trap = trap_q;
`else
  assign bus.o_trap = 1'b0;
`endif

  assign bus.o_imem_req  = ireq_q;
  assign bus.o_imem_addr = pc_q;
  assign bus.o_ir        = ir_q;
  assign bus.o_pc        = pc_q;
  assign bus.o_dmem_req  = dreq_q;
  assign bus.o_dmem_we   = dwe_q;
  assign bus.o_dmem_addr = daddr_q;
  assign bus.o_rf_we     = rfwe_q;
  assign bus.o_wb_sel    = wbsel_q;
  assign bus.o_state     = state_q;
endmodule

// File: tb/tb_rv32i_sequencer.sv
// Bench for rv32i_sequencer: acts as memories and decoder, checks each
// instruction's observed timing/strobes against a per-instruction model.
module tb_rv32i_sequencer;
  import rv32i_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TV     = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mpc;

  always #5 clk = ~clk;

  rv32i_sequencer_if bus();
  rv32i_sequencer dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(bus.o_state), 32'd0);
    chk({tag, "_pc"}, bus.o_pc, RST_PC);
    chk({tag, "_ir"}, bus.o_ir, 32'h0000_0013);
    chk({tag, "_imem_req"}, 32'(bus.o_imem_req), 32'd0);
    chk({tag, "_dmem_req"}, 32'(bus.o_dmem_req), 32'd0);
    chk({tag, "_dmem_we"}, 32'(bus.o_dmem_we), 32'd0);
    chk({tag, "_dmem_addr"}, bus.o_dmem_addr, 32'd0);
    chk({tag, "_rf_we"}, 32'(bus.o_rf_we), 32'd0);
    chk({tag, "_wb_sel"}, 32'(bus.o_wb_sel), 32'd0);
    chk({tag, "_trap"}, 32'(bus.o_trap), 32'd0);
  endtask

  // Entered at a negedge where a fetch request for mpc is visible; returns at the
  // negedge where the following fetch request first appears.
  task automatic run_instr(input string tag, input logic [31:0] instr, input int iwait,
                           input int dwait, input logic ill, input logic [31:0] alu,
                           input logic [31:0] jaddr, input logic [31:0] btgt);
    logic [6:0]  opc;
    logic [1:0]  jmp;
    logic [31:0] tgt, exp_pc, addr0, daddr0;
    logic        taken, is_mem, trap, wr, seen_low, istable, dstable, dwe0;
    logic [1:0]  exp_sel, sel_obs;
    int exp_lat, cyc, icyc, dcyc, rfn, trn, rfcyc, trcyc, iw, dw;
    opc = instr[6:0];
    jmp = ill ? 2'd0 : (opc == OPC_JAL) ? 2'd1 : (opc == OPC_JALR) ? 2'd2 :
          (opc == OPC_BRANCH) ? 2'd3 : 2'd0;
    taken = (jmp == 2'd1) || (jmp == 2'd2) || (jmp == 2'd3 && alu[0]);
    if (jmp == 2'd1)                tgt = jaddr;
    else if (jmp == 2'd2)           tgt = alu & 32'hFFFF_FFFE;
    else if (jmp == 2'd3 && alu[0]) tgt = btgt;
    else                            tgt = mpc + 32'd4;
    is_mem = !ill && (opc == OPC_LOAD || opc == OPC_STORE);
    trap = 1'b0;
`ifdef RV32I_SEQ_TRAP_EN
    trap = ill || (taken && tgt[1]);
`endif
    wr = !ill && !trap && instr[11:7] != 5'd0 &&
         (opc == OPC_LOAD || opc == OPC_OP || opc == OPC_OP_IMM || opc == OPC_LUI ||
          opc == OPC_AUIPC || opc == OPC_JAL || opc == OPC_JALR);
    exp_sel = (opc == OPC_LOAD) ? 2'd1 : (opc == OPC_JAL || opc == OPC_JALR) ? 2'd2 : 2'd0;
    exp_pc  = trap ? TV : tgt;
    exp_lat = ill ? 3 + iwait : trap ? 4 + iwait : is_mem ? 5 + iwait + dwait : 4 + iwait;

    bus.i_illegal = ill; bus.i_jump = jmp; bus.i_alu_result = alu;
    bus.i_jump_addr = jaddr; bus.i_branch_target = btgt;
    cyc = 0; icyc = 0; dcyc = 0; rfn = 0; trn = 0; rfcyc = 0; trcyc = 0; iw = 0; dw = 0;
    seen_low = 1'b0; istable = 1'b1; dstable = 1'b1; dwe0 = 1'b0; daddr0 = '0; sel_obs = '0;
    addr0 = bus.o_imem_addr;
    while (cyc < 60) begin
      if (bus.o_imem_req) begin
        if (seen_low) break;
        icyc++;
        if (bus.o_imem_addr !== addr0) istable = 1'b0;
        bus.i_imem_ack = (iw == iwait); bus.i_imem_rdata = instr; iw++;
      end else begin
        seen_low = 1'b1;
        bus.i_imem_ack = 1'($urandom_range(0, 1)); bus.i_imem_rdata = $urandom;
      end
      if (bus.o_dmem_req) begin
        if (dcyc == 0) begin daddr0 = bus.o_dmem_addr; dwe0 = bus.o_dmem_we; end
        else if (bus.o_dmem_addr !== daddr0 || bus.o_dmem_we !== dwe0) dstable = 1'b0;
        dcyc++;
        bus.i_dmem_ack = (dw == dwait); dw++;
      end else begin
        bus.i_dmem_ack = 1'($urandom_range(0, 1));
      end
      cyc++;
      if (bus.o_rf_we) begin rfn++; rfcyc = cyc; sel_obs = bus.o_wb_sel; end
      if (bus.o_trap)  begin trn++; trcyc = cyc; end
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_next_addr"}, bus.o_imem_addr, exp_pc);
    chk({tag, "_ir"}, bus.o_ir, instr);
    chk({tag, "_imem_cycles"}, 32'(icyc), 32'(iwait + 1));
    chk({tag, "_imem_stable"}, 32'(istable), 32'd1);
    chk({tag, "_rf_we_count"}, 32'(rfn), 32'(wr));
    if (wr) begin
      chk({tag, "_wb_sel"}, 32'(sel_obs), 32'(exp_sel));
      chk({tag, "_rf_we_cycle"}, 32'(rfcyc), 32'(exp_lat));
    end
    chk({tag, "_trap_count"}, 32'(trn), 32'(trap));
    if (trap) chk({tag, "_trap_cycle"}, 32'(trcyc), 32'(exp_lat));
    chk({tag, "_dmem_cycles"}, 32'(dcyc), is_mem ? 32'(dwait + 1) : 32'd0);
    if (is_mem) begin
      chk({tag, "_dmem_we"}, 32'(dwe0), 32'(opc == OPC_STORE));
      chk({tag, "_dmem_addr"}, daddr0, alu);
      chk({tag, "_dmem_stable"}, 32'(dstable), 32'd1);
    end
    mpc = exp_pc;
  endtask

  initial begin
    logic [6:0]  ropc;
    logic [31:0] rinstr;
    int kind, n;
    bus.i_imem_ack = 0; bus.i_imem_rdata = '0; bus.i_illegal = 0; bus.i_jump = '0;
    bus.i_jump_addr = '0; bus.i_branch_target = '0; bus.i_alu_result = '0; bus.i_dmem_ack = 0;
    mpc = RST_PC;
    @(negedge clk); @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_imem_req", 32'(bus.o_imem_req), 32'd1);
    chk("first_imem_addr", bus.o_imem_addr, RST_PC);

    run_instr("addi_x1", 32'h0050_0093, 0, 0, 1'b0, 32'd5, 32'd0, 32'd0);
    run_instr("addi_iwait3", 32'h0050_0093, 3, 0, 1'b0, 32'd5, 32'd0, 32'd0);
    run_instr("lw_dwait2", 32'h0000_A103, 0, 2, 1'b0, 32'h0000_1234, 32'd0, 32'd0);
    run_instr("jal_to_40", 32'h0000_006F, 0, 0, 1'b0, 32'd0, 32'h40, 32'd0);
    run_instr("beq_taken", 32'h0000_0063, 0, 0, 1'b0, 32'd1, 32'd0, 32'h20);
    run_instr("jal_to_40b", 32'h0000_006F, 1, 0, 1'b0, 32'd0, 32'h40, 32'd0);
    run_instr("beq_not_taken", 32'h0000_0063, 0, 0, 1'b0, 32'd0, 32'd0, 32'h20);
    run_instr("jalr", 32'h0000_80E7, 0, 0, 1'b0, 32'h101, 32'd0, 32'd0);
    run_instr("illegal", 32'hFFFF_FFFF, 0, 0, 1'b1, 32'd0, 32'd0, 32'd0);
    run_instr("sw", 32'h0020_A023, 1, 1, 1'b0, 32'h0000_0F00, 32'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: ropc = OPC_OP_IMM;  1: ropc = OPC_OP;    2: ropc = OPC_LUI;
        3: ropc = OPC_AUIPC;   4: ropc = OPC_LOAD;  5: ropc = OPC_STORE;
        6: ropc = OPC_JAL;     7: ropc = OPC_JALR;  8: ropc = OPC_BRANCH;
        default: ropc = 7'b1111111;
      endcase
      rinstr = $urandom;
      rinstr[6:0] = ropc;
      run_instr("rand", rinstr, $urandom_range(0, 3), $urandom_range(0, 3), kind == 9,
                $urandom, $urandom & 32'h0000_0FFE, $urandom & 32'h0000_0FFE);
    end

    // Asynchronous reset with a data request outstanding.
    bus.i_illegal = 0; bus.i_jump = '0; bus.i_alu_result = 32'h0000_0ABC; bus.i_dmem_ack = 0;
    bus.i_imem_ack = 1; bus.i_imem_rdata = 32'h0000_A103;
    @(negedge clk);
    bus.i_imem_ack = 0;
    n = 0;
    while (!bus.o_dmem_req && n < 20) begin @(negedge clk); n++; end
    chk("mem_pending", 32'(bus.o_dmem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    mpc = RST_PC;
    @(negedge clk);
    chk("restart_imem_req", 32'(bus.o_imem_req), 32'd1);
    chk("restart_imem_addr", bus.o_imem_addr, RST_PC);
    run_instr("after_reset", 32'h0050_0093, 0, 0, 1'b0, 32'd5, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
